// File: rtl/regbank_write_arbiter_if.sv
// Requester and fill handshakes plus bank readout for regbank_write_arbiter.
// Signal names carry the arbiter-side direction prefix.
interface regbank_write_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [N_REQ-1:0] i_req_valid;
  logic [AW-1:0]    i_req_addr [N_REQ];
  logic [W-1:0]     i_req_data [N_REQ];
  logic [N_REQ-1:0] o_req_ready;
  logic             i_fill_valid;
  logic [W-1:0]     i_fill_data;
  logic             o_fill_ready;
  logic             o_busy;
  logic [W-1:0]     o_entry [DEPTH];

  modport master (
    output i_req_valid, i_req_addr, i_req_data, i_fill_valid, i_fill_data,
    input  o_req_ready, o_fill_ready, o_busy, o_entry
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_data, i_fill_valid, i_fill_data,
    output o_req_ready, o_fill_ready, o_busy, o_entry
  );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Round-robin write arbiter for a DEPTH-entry register bank with a broadcast
// fill sequence that has absolute priority over single-entry writes.
module regbank_write_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input logic                   i_clk,
  input logic                   i_rst,
  regbank_write_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {StIdle, StFill} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [W-1:0]     fill_q, fill_d;
  logic [W-1:0]     entry_q [DEPTH];

  logic             found;
  logic [PW-1:0]    gidx;
  logic [PW-1:0]    cand;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [W-1:0]     wr_data;
  logic [N_REQ-1:0] req_ready;
  logic             fill_ready;
  logic             busy;

  // First asserted valid at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = PW'((32'(ptr_q) + i) % N_REQ);
      if (!found && bus.i_req_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    fill_d     = fill_q;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    req_ready  = '0;
    fill_ready = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_fill_valid) begin
          fill_ready = 1'b1;
          fill_d     = bus.i_fill_data;
          idx_d      = '0;
          state_d    = StFill;
        end else if (found) begin
          req_ready[gidx] = 1'b1;
          wr_en           = 1'b1;
          wr_addr         = bus.i_req_addr[gidx];
          wr_data         = bus.i_req_data[gidx];
          ptr_d           = PW'((32'(gidx) + 1) % N_REQ);
        end
      end
      StFill: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = idx_q;
        wr_data = fill_q;
        if (idx_q == AW'(DEPTH - 1)) begin
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      fill_q  <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      if (wr_en) entry_q[wr_addr] <= wr_data;
    end
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_fill_ready = fill_ready;
  assign bus.o_busy       = busy;
  assign bus.o_entry      = entry_q;
endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Sequencing and arbitration controller for a shared 8-entry unpacked register bank. Several requesters compete for single-entry writes through valid/ready handshakes, granted round-robin. A broadcast fill operation writes one value into every entry, one entry per cycle. Holds the bank and drives it as an unpacked array output for downstream logic.

## Interface

- N_REQ, 4, number of write requesters (2..8)
- W, 8, entry data width
- DEPTH, 8, number of bank entries; index width AW = $clog2(DEPTH)
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_req_valid  input  [N_REQ-1:0]  requester k has a pending write
- i_req_addr  input  unpacked [N_REQ] of AW  target entry per requester
- i_req_data  input  unpacked [N_REQ] of W  write data per requester
- o_req_ready  output  [N_REQ-1:0]  one-hot (or zero) grant; write taken when valid&ready at edge
- i_fill_valid  input  1  broadcast fill request
- i_fill_data  input  W  fill value
- o_fill_ready  output  1  fill accepted when valid&ready at edge
- o_busy  output  1  fill sequence in progress
- o_entry  output  unpacked [DEPTH] of W  current bank contents

## Operation

- States: IDLE, FILL. Reset -> IDLE.
- IDLE, i_fill_valid=1: o_fill_ready=1, all o_req_ready=0 (fill has absolute priority). On edge: capture i_fill_data into fill register, idx<=0, -> FILL.
- IDLE, i_fill_valid=0: round-robin among asserted i_req_valid, search starting at pointer p. Winner g gets o_req_ready[g]=1 combinationally; others 0. On edge: o_entry[i_req_addr[g]] <= i_req_data[g]; p <= (g+1) mod N_REQ. No valid -> no grant, p unchanged.
- FILL: o_busy=1, o_fill_ready=0, o_req_ready=0. Each edge: o_entry[idx] <= fill register; idx increments. Edge that writes idx=DEPTH-1 -> IDLE, idx<=0.
- Ready outputs never depend on ready (no combinational loop); ready depends only on state, p, valids, i_fill_valid.
- Requesters held off by fill keep valid asserted; grant resumes from unchanged p after FILL.
- idx is AW bits; no wrap beyond DEPTH-1.
- Reset (async, any time incl. mid-FILL): all o_entry=0, p=0, idx=0, fill register=0, state IDLE; o_req_ready, o_fill_ready recompute combinationally from IDLE.

## Timing

- Reset values: o_entry all 0, o_busy=0, o_req_ready=grant of requester-0-first RR on current valids, o_fill_ready=i_fill_valid.
- Grant latency: 0 cycles (same-cycle ready). Written value visible on o_entry one cycle after the handshake edge.
- Throughput: one requester write per cycle in IDLE.
- Fill accepted at edge T: o_busy=1 for cycles T..T+DEPTH-1 (DEPTH cycles); o_entry[k] updates at edge T+1+k; IDLE again after edge T+DEPTH; o_fill_ready may reassert in the cycle after the final write.
- A fill arriving while in FILL waits (ready=0) until IDLE; back-to-back fills separated by no idle cycle.
- Two requesters targeting same address in consecutive cycles: later write wins.

## Test plan

- Reset then idle: after i_rst pulse, all o_entry=0, o_busy=0, o_req_ready=0 with no valids; assert i_rst mid-cycle (asynchronous) clears immediately.
- Round-robin: N_REQ=4, all valid continuously, addr k=k, data k=0x10+k -> grants 0,1,2,3,0,... one per cycle; o_entry[k]=0x10+k one cycle after each grant.
- Pointer skip: only req 2 and 0 valid with p=0 -> grant 0, then 2, then 0; req 3 valid alone -> granted immediately.
- Fill: i_fill_data=0xA5 accepted at edge T with req 1 valid -> o_busy 8 cycles, o_entry[k]=0xA5 at T+1+k, req 1 ready=0 throughout, granted first cycle after FILL.
- Reset mid-fill: i_rst asserted after entry 3 written -> all entries 0, IDLE, o_busy=0; fill does not resume.
- Fill priority: i_fill_valid and all req valid same cycle -> o_fill_ready=1, all o_req_ready=0; no entry written by requesters at that edge.
